// File: rtl/mult_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states, Booth
// operation codes and the default operand width.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB
    } booth_op_t;

    // Radix-2 Booth recoding of the current multiplier bit pair {q0, q-1}.
    function automatic booth_op_t booth_decode(input logic q0, input logic q_m1);
        case ({q0, q_m1})
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/seq_booth_multiplier_if.sv
// Request/result bundle of the sequential Booth multiplier; the master
// issues start with operands, the slave reports busy/done/product.
interface seq_booth_multiplier_if
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/booth_addsub32.sv
// Plain ripple adder with carry-in; subtraction is done by the caller
// passing the inverted operand with cin=1.
module booth_addsub32
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH + 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    logic [WIDTH:0] full;

    assign full     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sum      = full[WIDTH-1:0];
    assign cout     = full[WIDTH];
    assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/seq_booth_multiplier.sv
// Sequential radix-2 Booth multiplier: one add/sub-and-shift step per clock,
// WIDTH steps per product, with a one-cycle done pulse.
module seq_booth_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_booth_multiplier_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t             state;
    state_t             next_state;
    logic               load;
    logic               step;
    logic               busy;
    logic               done;

    logic [WIDTH:0]     m;
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   q;
    logic               q_m1;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] product;

    booth_op_t          op;
    logic               sub;
    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     acc_new;
    logic [WIDTH:0]     acc_shift;
    logic [WIDTH-1:0]   q_shift;
    logic               cout;
    logic               ovf;
    logic               addsub_unused;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // DONE accepts a new start directly so back-to-back products lose no cycle.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (count == CW'(1)) next_state = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (bus.start) begin
                    next_state = RUN;
                    load       = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign op     = booth_decode(q[0], q_m1);
    assign sub    = (op == OP_SUB);
    assign addend = sub ? ~m : m;

    booth_addsub32 #(.WIDTH(WIDTH + 1)) u_addsub (
        .a        (acc),
        .b        (addend),
        .cin      (sub),
        .sum      (sum),
        .cout     (cout),
        .overflow (ovf)
    );

    // The extra accumulator bit absorbs the -2^(WIDTH-1) multiplicand case.
    assign addsub_unused = cout ^ ovf;
    assign acc_new       = (op == OP_NOP) ? acc : sum;
    assign acc_shift     = {acc_new[WIDTH], acc_new[WIDTH:1]};
    assign q_shift       = {acc_new[0], q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m       <= '0;
            acc     <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            count   <= '0;
            product <= '0;
        end else if (load) begin
            m     <= {bus.a[WIDTH-1], bus.a};
            acc   <= '0;
            q     <= bus.b;
            q_m1  <= 1'b0;
            count <= CW'(WIDTH);
        end else if (step) begin
            acc   <= acc_shift;
            q     <= q_shift;
            q_m1  <= q[0];
            count <= count - CW'(1);
            if (count == CW'(1)) product <= {acc_shift[WIDTH-1:0], q_shift};
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = product;
endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Directed bench for seq_booth_multiplier: hand-computed products, latency,
// start-ignore while busy, back-to-back start and mid-run reset.
module tb_seq_booth_multiplier;
    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   n;

    seq_booth_multiplier_if #(.WIDTH(W)) bus ();

    seq_booth_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [2*W-1:0] observed,
                               input logic [2*W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
    endtask

    // Operands are scrambled right after acceptance; the result must not care.
    task automatic waitDone(output int cyc);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~bus.a;
        bus.b     = ~bus.b;
        cyc       = 1;
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic checkResult(input string tag, input logic [2*W-1:0] expected);
        int cyc;
        waitDone(cyc);
        checkOutput({tag, "_latency"}, 64'(cyc), 64'd33);
        checkOutput({tag, "_product"}, bus.product, expected);
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, {63'b0, bus.done}, 64'd0);
        checkOutput({tag, "_held"}, bus.product, expected);
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", {63'b0, bus.busy}, 64'd0);
        checkOutput("reset_done", {63'b0, bus.done}, 64'd0);
        checkOutput("reset_product", bus.product, 64'd0);

        $display("[TB] largest positive operands, start on first edge after reset");
        rst_n = 1'b1;
        applyStimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        checkResult("max_pos", 64'h3FFF_FFFF_0000_0001);

        applyStimulus(32'h8000_0000, 32'h8000_0000);
        checkResult("min_sq", 64'h4000_0000_0000_0000);

        applyStimulus(32'h8000_0000, 32'h0000_0001);
        checkResult("min_x1", 64'hFFFF_FFFF_8000_0000);

        applyStimulus(32'hFFFF_FFFB, 32'h0000_0003);
        checkResult("neg5_x3", 64'hFFFF_FFFF_FFFF_FFF1);

        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkResult("neg1_sq", 64'h0000_0000_0000_0001);

        applyStimulus(32'h1234_5678, 32'h0000_0000);
        checkResult("times_zero", 64'h0);

        $display("[TB] start pulse with new operands during RUN");
        applyStimulus(32'h0000_1000, 32'h0000_0010);
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        repeat (4) begin
            @(negedge clk);
            n++;
        end
        checkOutput("run_busy", {63'b0, bus.busy}, 64'd1);
        applyStimulus(32'h0000_FFFF, 32'h0000_FFFF);
        @(negedge clk);
        n++;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ignore_latency", 64'(n), 64'd33);
        checkOutput("ignore_product", bus.product, 64'h0000_0000_0001_0000);
        @(negedge clk);
        checkOutput("ignore_idle_busy", {63'b0, bus.busy}, 64'd0);

        $display("[TB] back-to-back start held in DONE cycle");
        applyStimulus(32'd6, 32'd7);
        waitDone(n);
        checkOutput("b2b_first_latency", 64'(n), 64'd33);
        checkOutput("b2b_first_product", bus.product, 64'h2A);
        applyStimulus(32'd3, 32'd4);
        checkResult("b2b_second", 64'h0000_0000_0000_000C);

        $display("[TB] reset pulse at RUN cycle 10");
        applyStimulus(32'h0000_0100, 32'h0000_0100);
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        repeat (9) begin
            @(negedge clk);
            n++;
        end
        checkOutput("midrun_busy_before", {63'b0, bus.busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_busy", {63'b0, bus.busy}, 64'd0);
        checkOutput("midrun_done", {63'b0, bus.done}, 64'd0);
        checkOutput("midrun_product", bus.product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(32'h0001_0001, 32'h0001_0001);
        checkResult("post_reset", 64'h0000_0001_0002_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_booth_multiplier.md
SEQ_BOOTH_MULTIPLIER -- requirements
Module: seq_booth_multiplier

Interface
REQ-001 SHALL provide parameter: WIDTH, 32, operand width in bits; product is 2*WIDTH bits.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: start  input  1  request to begin a multiply.
REQ-005 SHALL have port: a  input  WIDTH  signed two's-complement multiplicand.
REQ-006 SHALL have port: b  input  WIDTH  signed two's-complement multiplier.
REQ-007 SHALL have port: busy  output  1  high while an operation is in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; product valid.
REQ-009 SHALL have port: product  output  2*WIDTH  signed result a*b, held until the next accepted start.
REQ-010 SHALL use one clock (clk); reset is asynchronous and active-low (rst_n).

Function
REQ-011 SHALL implement radix-2 Booth, one iteration per clock: {q0,q-1}=01 add multiplicand, 10 subtract multiplicand, 00/11 no-op, then arithmetic shift right of {acc,q,q-1} by one.
REQ-012 SHALL hold the accumulator at WIDTH+1 bits, sign-extended, so a = -2^(WIDTH-1) never overflows.
REQ-013 SHALL implement subtraction as add of ~M with carry-in 1 through the add/sub sub-module.
REQ-014 SHALL have FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-015 SHALL transition IDLE->RUN on start=1: latch a, load acc=0, q=b, q-1=0, counter=WIDTH.
REQ-016 SHALL decrement the counter once per RUN cycle and go RUN->DONE when the WIDTH-th iteration completes.
REQ-017 SHALL assert done one cycle in DONE only, i.e. WIDTH+1 clocks after the start-sampling edge.
REQ-018 SHALL update product at the RUN->DONE edge and hold it otherwise.
REQ-019 SHALL drive busy=1 in RUN, 0 in IDLE and DONE.
REQ-020 SHALL go DONE->IDLE when start=0, and DONE->RUN (new load, back-to-back) when start=1.
REQ-021 SHALL ignore start and any a/b changes while busy=1.
REQ-022 SHALL produce results independent of input values held after the accepted start edge.

Reset
REQ-023 SHALL on rst_n=0, at any time including mid-RUN, immediately force state IDLE, busy=0, done=0, product=0, and clear the accumulator, counter, and operand registers.
REQ-024 SHALL accept a start on the first rising edge after rst_n deasserts.

Structure
REQ-025 SHALL place the FSM state enum and the default WIDTH constant in shared package mult_pkg.
REQ-026 SHALL instantiate one sub-module, booth_addsub32, a WIDTH+1-bit adder (a, b, cin -> sum, cout, overflow) used for the Booth add/subtract; all sequencing stays in the top.

Verification
REQ-027 SHALL check a=7FFFFFFF, b=7FFFFFFF, start -> done exactly 33 clocks later, product=3FFFFFFF00000001.
REQ-028 SHALL check a=80000000, b=80000000 -> product=4000000000000000; a=80000000, b=00000001 -> FFFFFFFF80000000.
REQ-029 SHALL check a=FFFFFFFB (-5), b=00000003 -> FFFFFFFFFFFFFFF1, and a=FFFFFFFF, b=FFFFFFFF -> 0000000000000001.
REQ-030 SHALL check a=12345678, b=0 -> product=0; start pulsed with new a/b during RUN -> ignored, original result returned.
REQ-031 SHALL check start held high in the DONE cycle with a=3, b=4 -> second done 33 clocks later, product=000000000000000C.
REQ-032 SHALL check rst_n pulsed low at RUN cycle 10 -> busy=0, done=0, product=0 immediately; the next start completes correctly.
